// File: rtl/hbf2_dec_iq.sv
// hbf2_dec_iq: dual-channel (A/B) I/Q 23-tap half-band decimate-by-2 FIR
// that follows the CIC decimator. Each channel and axis keeps its own
// 32-deep circular delay line. A single pre-add/MAC sequencer per axis
// serves both channels.
// Optional feature macro: HBF2_BYPASS_EN adds the byp input. When byp is 1,
// each input sample is registered straight to the output and the filter is
// not used.
module hbf2_dec_iq (
  input  logic               clk,
  input  logic               rstb,
`ifdef HBF2_BYPASS_EN
  input  logic               byp,
`endif
  input  logic signed [17:0] din_i,
  input  logic signed [17:0] din_q,
  input  logic               din_vld,
  input  logic               din_ch,
  output logic signed [17:0] dout_i,
  output logic signed [17:0] dout_q,
  output logic               dout_vld,
  output logic               dout_ch,
  output logic               ovf,
  output logic               ovr
);

  // Symmetric even-tap coefficients in Q1.17. The centre tap is 65536 and
  // is applied as a shift. Their sum times two, plus the centre, is 2^17.
  localparam logic signed [17:0] H0 = 18'sd168;
  localparam logic signed [17:0] H1 = 18'sd1900;
  localparam logic signed [17:0] H2 = -18'sd3900;
  localparam logic signed [17:0] H3 = 18'sd7000;
  localparam logic signed [17:0] H4 = -18'sd13400;
  localparam logic signed [17:0] H5 = 18'sd41000;

  // Sequencer states. DRN drains the registered multiplier before rounding.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_CTR  = 3'd2;
  localparam logic [2:0] S_DRN  = 3'd3;
  localparam logic [2:0] S_RND  = 3'd4;

  // Delay lines, indexed [channel][address]; 1 = A, 0 = B
  logic signed [17:0] mem_i [2][32];
  logic signed [17:0] mem_q [2][32];
  logic [4:0]         wp [2];
  logic               ph [2];

  logic [2:0]         state;
  logic [2:0]         k;
  logic [4:0]         base;
  logic               cur_ch;
  logic signed [36:0] prod_i;
  logic signed [36:0] prod_q;
  logic signed [39:0] acc_i;
  logic signed [39:0] acc_q;

  logic               byp_on;
  logic               trig;
  logic               start;
  logic [4:0]         addr_a;
  logic [4:0]         addr_b;
  logic signed [17:0] coef;
  logic signed [17:0] rd_ia;
  logic signed [17:0] rd_ib;
  logic signed [17:0] rd_qa;
  logic signed [17:0] rd_qb;
  logic signed [18:0] pre_i;
  logic signed [18:0] pre_q;
  logic signed [36:0] mac_i;
  logic signed [36:0] mac_q;
  logic signed [36:0] ctr_i;
  logic signed [36:0] ctr_q;
  logic [18:0]        rnd_i;
  logic [18:0]        rnd_q;

`ifdef HBF2_BYPASS_EN
  assign byp_on = byp;
`else
  assign byp_on = 1'b0;
`endif

  // A sample that arrives while the channel phase bit is set is the second
  // sample of a pair, so it triggers one decimated output.
  assign trig  = din_vld & ph[din_ch] & ~byp_on;
  // The RND cycle hands the sequencer back, so a new run can start then.
  assign start = trig & ((state == S_IDLE) | (state == S_RND));

  // Round half up, then saturate to 18 bits. Bit 18 of the result flags
  // that the value was clipped.
  function automatic logic [18:0] rnd_sat(input logic signed [39:0] a);
    logic signed [39:0] s;
    s = (a + 40'sd65536) >>> 17;
    if (s > 40'sd131071)
      rnd_sat = {1'b1, 18'h1FFFF};
    else if (s < -40'sd131072)
      rnd_sat = {1'b1, 18'h20000};
    else
      rnd_sat = {1'b0, s[17:0]};
  endfunction

  // Pick the tap-pair read addresses and the coefficient for the current
  // step. The base is the address of the trigger sample, captured at start.
  // Later writes go above base, which the 9-entry margin keeps clear.
  always_comb begin
    coef   = H0;
    addr_a = base - {1'b0, k, 1'b0};
    addr_b = base - 5'd22 + {1'b0, k, 1'b0};
    case (k)
      3'd0:    coef = H0;
      3'd1:    coef = H1;
      3'd2:    coef = H2;
      3'd3:    coef = H3;
      3'd4:    coef = H4;
      3'd5:    coef = H5;
      default: coef = H0;
    endcase
    if (state == S_CTR)
      addr_a = base - 5'd11;
  end

  assign rd_ia = mem_i[cur_ch][addr_a];
  assign rd_ib = mem_i[cur_ch][addr_b];
  assign rd_qa = mem_q[cur_ch][addr_a];
  assign rd_qb = mem_q[cur_ch][addr_b];

  assign pre_i = {rd_ia[17], rd_ia} + {rd_ib[17], rd_ib};
  assign pre_q = {rd_qa[17], rd_qa} + {rd_qb[17], rd_qb};

  assign mac_i = $signed({{19{coef[17]}}, coef}) * $signed({{18{pre_i[18]}}, pre_i});
  assign mac_q = $signed({{19{coef[17]}}, coef}) * $signed({{18{pre_q[18]}}, pre_q});

  assign ctr_i = {{3{rd_ia[17]}}, rd_ia, 16'h0000};
  assign ctr_q = {{3{rd_qa[17]}}, rd_qa, 16'h0000};

  assign rnd_i = rnd_sat(acc_i);
  assign rnd_q = rnd_sat(acc_q);

  // Write every incoming sample into its channel's lines. There is no reset
  // here, so this maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      mem_i[din_ch][wp[din_ch]] <= din_i;
      mem_q[din_ch][wp[din_ch]] <= din_q;
    end
  end

  // Advance the channel's write pointer and flip its pair phase on each sample
  always_ff @(posedge clk) begin
    if (rstb) begin
      wp[0] <= 5'd0;
      wp[1] <= 5'd0;
      ph[0] <= 1'b0;
      ph[1] <= 1'b0;
    end else if (din_vld) begin
      wp[din_ch] <= wp[din_ch] + 5'd1;
      ph[din_ch] <= ~ph[din_ch];
    end
  end

  // Sequencer. MAC runs one pair per cycle through a registered product.
  // CTR adds the centre tap, DRN adds the last product, and RND registers
  // the rounded, saturated result.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state    <= S_IDLE;
      k        <= 3'd0;
      base     <= 5'd0;
      cur_ch   <= 1'b0;
      prod_i   <= '0;
      prod_q   <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      dout_i   <= '0;
      dout_q   <= '0;
      dout_vld <= 1'b0;
      dout_ch  <= 1'b0;
      ovf      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      ovf      <= 1'b0;

      if (trig && !start)
        ovr <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_MAC;
            k      <= 3'd0;
            base   <= wp[din_ch];
            cur_ch <= din_ch;
          end
        end
        S_MAC: begin
          prod_i <= mac_i;
          prod_q <= mac_q;
          if (k == 3'd0) begin
            acc_i <= '0;
            acc_q <= '0;
          end else begin
            acc_i <= acc_i + {{3{prod_i[36]}}, prod_i};
            acc_q <= acc_q + {{3{prod_q[36]}}, prod_q};
          end
          if (k == 3'd5)
            state <= S_CTR;
          else
            k <= k + 3'd1;
        end
        S_CTR: begin
          prod_i <= ctr_i;
          prod_q <= ctr_q;
          acc_i  <= acc_i + {{3{prod_i[36]}}, prod_i};
          acc_q  <= acc_q + {{3{prod_q[36]}}, prod_q};
          state  <= S_DRN;
        end
        S_DRN: begin
          acc_i <= acc_i + {{3{prod_i[36]}}, prod_i};
          acc_q <= acc_q + {{3{prod_q[36]}}, prod_q};
          state <= S_RND;
        end
        S_RND: begin
          dout_i   <= rnd_i[17:0];
          dout_q   <= rnd_q[17:0];
          dout_ch  <= cur_ch;
          dout_vld <= 1'b1;
          ovf      <= rnd_i[18] | rnd_q[18];
          if (start) begin
            state  <= S_MAC;
            k      <= 3'd0;
            base   <= wp[din_ch];
            cur_ch <= din_ch;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (din_vld && byp_on) begin
        dout_i   <= din_i;
        dout_q   <= din_q;
        dout_ch  <= din_ch;
        dout_vld <= 1'b1;
        ovf      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hbf2_dec_iq.sv
// tb_hbf2_dec_iq: scoreboard bench for hbf2_dec_iq. A direct-form reference
// model of the half-band filter pushes the expected outputs when samples are
// driven. A monitor pops them when dout_vld fires and compares them.
module tb_hbf2_dec_iq;

  logic               clk = 1'b0;
  logic               rstb = 1'b1;
  logic signed [17:0] din_i = '0;
  logic signed [17:0] din_q = '0;
  logic               din_vld = 1'b0;
  logic               din_ch = 1'b0;
  logic signed [17:0] dout_i;
  logic signed [17:0] dout_q;
  logic               dout_vld;
  logic               dout_ch;
  logic               ovf;
  logic               ovr;
`ifdef HBF2_BYPASS_EN
  logic               byp = 1'b0;
`endif

  hbf2_dec_iq dut (
    .clk      (clk),
    .rstb     (rstb),
`ifdef HBF2_BYPASS_EN
    .byp      (byp),
`endif
    .din_i    (din_i),
    .din_q    (din_q),
    .din_vld  (din_vld),
    .din_ch   (din_ch),
    .dout_i   (dout_i),
    .dout_q   (dout_q),
    .dout_vld (dout_vld),
    .dout_ch  (dout_ch),
    .ovf      (ovf),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit ch;
    int i;
    int q;
    bit ovf;
    bit chk;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   hc[6] = '{168, 1900, -3900, 7000, -13400, 41000};
  int   hist_i [2][4096];
  int   hist_q [2][4096];
  int   cnt [2];
  bit   ph [2];
  int   last_acc;
  bit   exp_ovr;

  int   obs_i[$];
  int   obs_q[$];
  int   ovf_cnt = 0;
  int   last_i [2];
  int   last_q [2];

  task automatic model_reset();
    sb.delete();
    cnt      = '{0, 0};
    ph       = '{0, 0};
    last_acc = -1000;
    exp_ovr  = 1'b0;
  endtask

  task automatic model_push(input bit ch, input int vi, input int vq, input int e);
    exp_t   x;
    int     n;
    longint ai;
    longint aq;
    hist_i[ch][cnt[ch]] = vi;
    hist_q[ch][cnt[ch]] = vq;
    cnt[ch]++;
    if (ph[ch]) begin
      if (e - last_acc >= 9) begin
        last_acc = e;
        x.cyc = e + 9;
        x.ch  = ch;
        x.chk = (cnt[ch] >= 23);
        x.i   = 0;
        x.q   = 0;
        x.ovf = 1'b0;
        if (x.chk) begin
          n  = cnt[ch] - 1;
          ai = 0;
          aq = 0;
          for (int j = 0; j < 6; j++) begin
            ai += longint'(hc[j]) * (hist_i[ch][n - 2*j] + hist_i[ch][n - 22 + 2*j]);
            aq += longint'(hc[j]) * (hist_q[ch][n - 2*j] + hist_q[ch][n - 22 + 2*j]);
          end
          ai += 64'sd65536 * longint'(hist_i[ch][n - 11]);
          aq += 64'sd65536 * longint'(hist_q[ch][n - 11]);
          ai = (ai + 64'sd65536) >>> 17;
          aq = (aq + 64'sd65536) >>> 17;
          if (ai > 131071) begin ai = 131071; x.ovf = 1'b1; end
          if (ai < -131072) begin ai = -131072; x.ovf = 1'b1; end
          if (aq > 131071) begin aq = 131071; x.ovf = 1'b1; end
          if (aq < -131072) begin aq = -131072; x.ovf = 1'b1; end
          x.i = int'(ai);
          x.q = int'(aq);
        end
        sb.push_back(x);
      end else begin
        exp_ovr = 1'b1;
      end
    end
    ph[ch] = !ph[ch];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit ch, input int vi, input int vq, input int gap);
    din_i   = vi[17:0];
    din_q   = vq[17:0];
    din_ch  = ch;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    model_push(ch, vi, vq, cyc);
    if (gap > 1) idle(gap - 1);
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    din_vld = 1'b0;
    model_reset();
    idle(3);
    n_vec++; if (dout_vld !== 1'b0) begin n_err++; $display("[TB] FAIL reset_vld got %b want 0", dout_vld); end
    n_vec++; if (dout_i !== 18'sd0) begin n_err++; $display("[TB] FAIL reset_i got %0d want 0", dout_i); end
    n_vec++; if (dout_q !== 18'sd0) begin n_err++; $display("[TB] FAIL reset_q got %0d want 0", dout_q); end
    n_vec++; if (dout_ch !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ch got %b want 0", dout_ch); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovr got %b want 0", ovr); end
    rstb = 1'b0;
    idle(2);
  endtask

  task automatic test_dc();
    for (int s = 0; s < 40; s++) send(1'b1, 1000, -1000, 10);
    idle(12);
    n_vec++; if (last_i[1] !== 1000) begin n_err++; $display("[TB] FAIL dc_i got %0d want 1000", last_i[1]); end
    n_vec++; if (last_q[1] !== -1000) begin n_err++; $display("[TB] FAIL dc_q got %0d want -1000", last_q[1]); end
    n_vec++; if (ovf_cnt !== 0) begin n_err++; $display("[TB] FAIL dc_ovf got %0d pulses want 0", ovf_cnt); end
  endtask

  task automatic test_impulse_trig();
    int exp_imp[12] = '{84, 950, -1950, 3500, -6700, 20500, 20500, -6700, 3500, -1950, 950, 84};
    for (int s = 0; s < 23; s++) send(1'b1, 0, 0, 10);
    obs_i.delete();
    obs_q.delete();
    send(1'b1, 65536, -65536, 10);
    for (int s = 0; s < 22; s++) send(1'b1, 0, 0, 10);
    idle(12);
    n_vec++; if (obs_i.size() !== 12) begin n_err++; $display("[TB] FAIL imp_trig_count got %0d want 12", obs_i.size()); end
    for (int s = 0; s < 12 && s < obs_i.size(); s++) begin
      n_vec++;
      if (obs_i[s] !== exp_imp[s] || obs_q[s] !== -exp_imp[s]) begin
        n_err++;
        $display("[TB] FAIL imp_trig[%0d] got i=%0d q=%0d want i=%0d q=%0d", s, obs_i[s], obs_q[s], exp_imp[s], -exp_imp[s]);
      end
    end
  endtask

  task automatic test_impulse_nontrig();
    int want;
    obs_i.delete();
    obs_q.delete();
    send(1'b1, 65536, 0, 10);
    for (int s = 0; s < 23; s++) send(1'b1, 0, 0, 10);
    idle(12);
    n_vec++; if (obs_i.size() !== 12) begin n_err++; $display("[TB] FAIL imp_odd_count got %0d want 12", obs_i.size()); end
    for (int s = 0; s < 12 && s < obs_i.size(); s++) begin
      want = (s == 5) ? 32768 : 0;
      n_vec++;
      if (obs_i[s] !== want) begin
        n_err++;
        $display("[TB] FAIL imp_odd[%0d] got %0d want %0d", s, obs_i[s], want);
      end
    end
  endtask

  task automatic test_saturation();
    int pos[23];
    int neg[23];
    int hs;
    for (int m = 0; m < 23; m++) begin
      if (m == 11) hs = 1;
      else if (m % 2 == 1) hs = 0;
      else hs = hc[(m <= 10) ? m / 2 : (22 - m) / 2];
      pos[m] = (hs > 0) ? 131071 : (hs < 0) ? -131072 : 0;
      neg[m] = (hs > 0) ? -131072 : (hs < 0) ? 131071 : 0;
    end
    for (int s = 0; s < 23; s++) send(1'b1, 0, 0, 10);
    obs_i.delete();
    obs_q.delete();
    ovf_cnt = 0;
    for (int s = 22; s >= 0; s--) send(1'b1, pos[s], neg[s], 10);
    send(1'b1, 0, 0, 10);
    for (int s = 22; s >= 0; s--) send(1'b1, neg[s], pos[s], 10);
    idle(12);
    n_vec++; if (obs_i.size() !== 24) begin n_err++; $display("[TB] FAIL sat_count got %0d want 24", obs_i.size()); end
    if (obs_i.size() == 24) begin
      n_vec++; if (obs_i[11] !== 131071 || obs_q[11] !== -131072) begin n_err++; $display("[TB] FAIL sat_hi got i=%0d q=%0d want 131071/-131072", obs_i[11], obs_q[11]); end
      n_vec++; if (obs_i[23] !== -131072 || obs_q[23] !== 131071) begin n_err++; $display("[TB] FAIL sat_lo got i=%0d q=%0d want -131072/131071", obs_i[23], obs_q[23]); end
    end
    n_vec++; if (ovf_cnt < 2) begin n_err++; $display("[TB] FAIL sat_ovf got %0d pulses want >=2", ovf_cnt); end
  endtask

  task automatic test_interleave();
    for (int s = 0; s < 40; s++) begin
      send(1'b1, 5000, -300, 10);
      send(1'b0, -7000, 1234, 10);
    end
    idle(12);
    n_vec++; if (last_i[1] !== 5000 || last_q[1] !== -300) begin n_err++; $display("[TB] FAIL ilv_a got i=%0d q=%0d want 5000/-300", last_i[1], last_q[1]); end
    n_vec++; if (last_i[0] !== -7000 || last_q[0] !== 1234) begin n_err++; $display("[TB] FAIL ilv_b got i=%0d q=%0d want -7000/1234", last_i[0], last_q[0]); end
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("[TB] FAIL ilv_ovr got %b want 0", ovr); end
  endtask

  task automatic test_back_to_back();
    obs_i.delete();
    obs_q.delete();
    for (int s = 0; s < 16; s++) begin
      send(1'b1, s * 100 - 800, -s * 37, 5);
      send(1'b1, s * 90 + 50, s * 41 - 300, 4);
    end
    idle(12);
    n_vec++; if (obs_i.size() !== 16) begin n_err++; $display("[TB] FAIL b2b_count got %0d want 16", obs_i.size()); end
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_ovr got %b want 0", ovr); end
  endtask

  task automatic test_overrun();
    obs_i.delete();
    obs_q.delete();
    send(1'b1, 300, 200, 2);
    send(1'b1, 400, -100, 2);
    send(1'b1, -500, 700, 2);
    send(1'b1, 600, 800, 10);
    idle(12);
    n_vec++; if (obs_i.size() !== 1) begin n_err++; $display("[TB] FAIL ovr_count got %0d want 1", obs_i.size()); end
    n_vec++; if (ovr !== exp_ovr || exp_ovr !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_set got %b want 1", ovr); end
    send(1'b1, 10, 20, 10);
    send(1'b1, 30, 40, 10);
    idle(12);
    n_vec++; if (ovr !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_sticky got %b want 1", ovr); end
    obs_i.delete();
    obs_q.delete();
    send(1'b1, 1111, 2222, 3);
    send(1'b1, 3333, 4444, 4);
    rstb = 1'b1;
    model_reset();
    idle(2);
    rstb = 1'b0;
    idle(15);
    n_vec++; if (obs_i.size() !== 0) begin n_err++; $display("[TB] FAIL rst_mid_out got %0d outputs want 0", obs_i.size()); end
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_ovr got %b want 0", ovr); end
  endtask

  initial begin
    model_reset();
    last_i = '{0, 0};
    last_q = '{0, 0};
    fork
      begin
        exp_t        m;
        logic [17:0] ei;
        logic [17:0] eq;
        forever begin
          @(negedge clk);
          while (sb.size() > 0 && sb[0].cyc < cyc) begin
            m = sb.pop_front();
            n_vec++;
            n_err++;
            $display("[TB] FAIL missing_out got no dout_vld want output at cycle %0d ch %0b", m.cyc, m.ch);
          end
          if (dout_vld) begin
            obs_i.push_back(int'(dout_i));
            obs_q.push_back(int'(dout_q));
            last_i[dout_ch] = int'(dout_i);
            last_q[dout_ch] = int'(dout_q);
            if (ovf) ovf_cnt++;
            if (sb.size() == 0) begin
              n_vec++;
              n_err++;
              $display("[TB] FAIL unexpected_vld got dout_vld at cycle %0d want none", cyc);
            end else begin
              m = sb.pop_front();
              n_vec++;
              if (m.cyc !== cyc || m.ch !== dout_ch) begin
                n_err++;
                $display("[TB] FAIL out_timing got cycle %0d ch %0b want cycle %0d ch %0b", cyc, dout_ch, m.cyc, m.ch);
              end
              if (m.chk) begin
                ei = m.i[17:0];
                eq = m.q[17:0];
                n_vec++;
                if (dout_i !== ei || dout_q !== eq || ovf !== m.ovf) begin
                  n_err++;
                  $display("[TB] FAIL out_value got i=%0d q=%0d ovf=%b want i=%0d q=%0d ovf=%b", dout_i, dout_q, ovf, m.i, m.q, m.ovf);
                end
              end
            end
          end else if (ovf) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL ovf_no_vld got ovf=1 want 0 at cycle %0d", cyc);
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    test_reset();
    test_dc();
    test_impulse_trig();
    test_impulse_nontrig();
    test_saturation();
    test_interleave();
    test_back_to_back();
    test_overrun();
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
